if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction fetch unit that drives the IF/ID pipeline register inputs (PC_in, Instruction_in) and generates its Flush. It owns the program counter and runs a request/ready handshake to instruction memory. It buffers up to two fetched instructions so that fetch continues while the pipeline is frozen, and it redirects on a taken branch.

## Interface
- RESET_PC, 32'h0000_0000, PC value fetched first after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- Freeze  in  1  pipeline stall from hazard unit; head entry is not consumed while high
- Branch_taken  in  1  taken-branch redirect from EXE stage
- Branch_Address  in  32  redirect target, valid when Branch_taken=1
- mem_req  out  1  instruction memory request
- mem_addr  out  32  word-aligned fetch address
- mem_ready  in  1  memory response strobe, qualifies mem_rdata in the same cycle
- mem_rdata  in  32  fetched instruction
- PC_out  out  32  to IF register PC_in: fetch address + 4 of the head entry, 0 when empty
- Instruction_out  out  32  to IF register Instruction_in: head instruction, 32'h0 (NOP) when empty
- Fetch_valid  out  1  head entry present
- Flush  out  1  equals Branch_taken (combinational), clears the IF register

## Operation
- State: pc (32 b), 2-entry FIFO of {pc+4, instr}, count (0..2), FSM {IDLE, REQ, WAIT_SPACE, DRAIN}.
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, count=0, FIFO pointers 0.
- Reset output values: mem_req=0, mem_addr=RESET_PC, PC_out=0, Instruction_out=0, Fetch_valid=0, Flush=Branch_taken.
- mem_req=1 in REQ and DRAIN only.
- mem_addr=pc in REQ. In DRAIN, mem_addr holds the address latched at the branch.
- Handshake rule: once mem_req rises, mem_req and mem_addr stay stable until mem_ready=1. No request is ever abandoned.
- Pop: occurs when count>0 and Freeze=0. PC_out and Instruction_out show the head entry.
- Push: in REQ with mem_ready=1 and Branch_taken=0:
  - write {pc+4, mem_rdata} to the FIFO;
  - pc <= pc+4 (mod 2^32, wraps from FFFF_FFFC to 0).
- Simultaneous push and pop: count is unchanged.
- Push is never issued when count=2, because the FSM leaves REQ first.
- FSM transitions (Branch_taken has highest priority):
  - IDLE -> REQ unconditionally on the next cycle.
  - REQ, Branch_taken=1, mem_ready=1: response is discarded; pc <= Branch_Address; stay in REQ.
  - REQ, Branch_taken=1, mem_ready=0: latch the outstanding address; pc <= Branch_Address; go to DRAIN.
  - REQ, push, count after this cycle = 2: go to WAIT_SPACE.
  - WAIT_SPACE, Branch_taken=1: pc <= Branch_Address; go to REQ.
  - WAIT_SPACE, pop: go to REQ.
  - DRAIN, mem_ready=1: response is discarded; go to REQ.
  - DRAIN, a second Branch_taken: pc is updated to the newer Branch_Address; stay in DRAIN until mem_ready.
- Branch_taken in any state:
  - FIFO is cleared (count <= 0); a pop in the same cycle is ignored;
  - Flush=1 in the same cycle.
- Branch_taken together with Freeze: the branch wins. The FIFO is cleared and Flush is asserted.

## Timing
- Zero-wait memory (mem_ready tied 1), Freeze=0: one instruction per cycle.
- Reset release at edge E0: IDLE during cycle 0, REQ for RESET_PC in cycle 1, first instruction at outputs in cycle 2.
- Fetch latency is 1 cycle after mem_ready: data pushed at the edge ending the ready cycle is visible at the outputs in the next cycle.
- Branch_taken in cycle N, not draining: request for Branch_Address in cycle N+1; with zero-wait memory that instruction appears at the outputs in cycle N+2.
- Branch_taken in cycle N with an outstanding request (DRAIN): the new request issues in the cycle after mem_ready.
- Freeze held: outputs stay constant, fetch continues until count=2, then mem_req=0.
- Freeze released with count=2: pop in that cycle; REQ resumes on the next cycle.

## Test plan
- Reset, RESET_PC=0x100, mem_ready=1, data=addr^0xA5A5A5A5 -> cycle 2: PC_out=0x104, Instruction_out=0xA5A5A4A5; cycle 3: PC_out=0x108; one instruction per cycle.
- Freeze high for 5 cycles mid-stream -> outputs frozen; exactly 2 entries buffered; mem_req low after fill; on release, sequence continues with no loss or duplication.
- mem_ready delayed 3 cycles -> mem_req/mem_addr stable throughout; Fetch_valid=0 and Instruction_out=0 while empty.
- Branch_taken=1, Branch_Address=0x200 with count=2 and Freeze=1 -> Flush=1 that cycle; count=0 next cycle; next valid output PC_out=0x204.
- Branch_taken while a request to 0x110 is outstanding -> mem_addr stays 0x110 until ready; that data is never output; next request is to the target.
- rst pulsed low in WAIT_SPACE -> all outputs at reset values immediately; restart fetching from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Small generic FIFO plus the instruction fetch unit that feeds the IF/ID register.
// Latency: fetched word visible at the outputs one cycle after mem_ready; branch target requested the next cycle.
// Backpressure: Freeze holds the head; fetch continues until two entries are buffered, then mem_req drops.

module fifo #(
    parameter  int DW    = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_rdy,
    output logic [DW-1:0] head_dat,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_rdy && (count != '0);
    assign do_push = push_vld && ((count != CW'(DEPTH)) || do_pop);

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_Address,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_out,
    output logic        Fetch_valid,
    output logic        Flush
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_SPACE, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] nxt_pc;
        logic [31:0] instr;
    } fetch_ent_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    fetch_ent_t  push_ent;
    fetch_ent_t  head_ent;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    // A branch flushes the queue, so the head is never consumed in that cycle.
    assign pop      = (count != 2'd0) && !Freeze && !Branch_taken;
    assign push     = (state == REQ) && mem_ready && !Branch_taken;
    assign push_ent = '{nxt_pc: pc + 32'd4, instr: mem_rdata};

    fifo #(.DW($bits(fetch_ent_t)), .DEPTH(2)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (Branch_taken),
        .push_vld (push),
        .push_dat (push_ent),
        .pop_rdy  (pop),
        .head_dat (head_ent),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (Branch_taken) pc <= Branch_Address;
                    state <= REQ;
                end
                REQ: begin
                    if (Branch_taken) begin
                        pc <= Branch_Address;
                        // Outstanding request must complete; remember its address.
                        if (!mem_ready) begin
                            drain_addr <= pc;
                            state      <= DRAIN;
                        end
                    end else if (mem_ready) begin
                        pc <= pc + 32'd4;
                        if ((count - {1'b0, pop}) == 2'd1) state <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (Branch_taken) begin
                        pc    <= Branch_Address;
                        state <= REQ;
                    end else if (pop) begin
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    if (Branch_taken) pc <= Branch_Address;
                    if (mem_ready) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req         = (state == REQ) || (state == DRAIN);
    assign mem_addr        = (state == DRAIN) ? drain_addr : pc;
    assign Fetch_valid     = (count != 2'd0);
    assign PC_out          = Fetch_valid ? head_ent.nxt_pc : 32'h0;
    assign Instruction_out = Fetch_valid ? head_ent.instr : 32'h0;
    assign Flush           = Branch_taken;
endmodule
